// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding, default memory depth, byte/word assembly constants and the
// word-index to byte-address mapping.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DEPTH_DEFAULT = 32;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 32;
    localparam int WORD_IDX_W    = 5;

    // Phase value of the fourth (least significant) byte of a word.
    localparam logic [1:0] LAST_PHASE = 2'd3;

    // Word index occupies byte-address bits [6:2]; bits [1:0] stay zero.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_IDX_W-1:0] idx);
        return {{(WORD_W-WORD_IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/inst_loader_pack.sv
// Byte-to-word packer: shifts accepted bytes in MSB first and publishes the
// completed big-endian word with a one-cycle word_valid strobe. The word
// register only changes on completion so it stays stable between strobes.
module inst_loader_pack
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        word_done
);

    logic [1:0]  phase;
    logic [23:0] partial;

    // Fourth byte of the current word is being accepted this cycle.
    assign word_done = byte_en && (phase == LAST_PHASE);

    // Phase counter, partial-word shifter and completed-word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= 2'd0;
            partial    <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_done;
            if (clear) begin
                phase <= 2'd0;
            end else if (byte_en) begin
                phase <= phase + 2'd1;
                if (word_done) begin
                    word <= {partial, byte_in};
                end else begin
                    partial <= {partial[15:0], byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Program loader for the single-cycle CPU's instruction RAM. Receives a
// count byte followed by big-endian instruction bytes over valid/ready,
// writes each word to the RAM, and holds the CPU while loading.
// Optional build macro: INST_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the load is reported done.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH         = DEPTH_DEFAULT,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [5:0]  words_loaded
);

    state_t      state, next_state;
    logic        accept;
    logic        start_go;
    logic        count_bad;
    logic        all_words;
    logic        word_done;
    logic [5:0]  target;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
    logic        csum_ok;
    assign csum_ok = (in_data == csum);
`endif

    assign accept    = in_valid && in_ready;
    assign start_go  = start && (state == S_IDLE);
    assign count_bad = {1'b0, in_data} > 9'(DEPTH);
    // All requested words have been accepted; input closes from here on.
    assign all_words = (words_loaded == target);

    inst_loader_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_go),
        .byte_en    (accept && (state == S_DATA)),
        .byte_in    (in_data),
        .word       (mem_wdata),
        .word_valid (mem_we),
        .word_done  (word_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; the session leaves DATA once the last word's write
    // strobe is on the bus so done trails the final write by one cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_COUNT;
            S_COUNT: if (accept) next_state = count_bad ? S_IDLE : S_DATA;
`ifdef INST_LOADER_CHECKSUM_EN
            S_DATA:  if (mem_we && all_words) next_state = S_CHECK;
            S_CHECK: if (accept) next_state = csum_ok ? S_DONE : S_IDLE;
`else
            S_DATA:  if (mem_we && all_words) next_state = S_DONE;
            S_CHECK: next_state = S_IDLE;
`endif
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake and completion outputs decoded from the state.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            S_COUNT: in_ready = 1'b1;
            S_DATA:  in_ready = !all_words;
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHECK: in_ready = 1'b1;
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Session bookkeeping: word count, write address, error flag, CPU hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            target       <= 6'd0;
            words_loaded <= 6'd0;
            mem_addr     <= 32'd0;
            err          <= 1'b0;
            cpu_hold     <= HOLD_AT_RESET;
`ifdef INST_LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
        end else begin
            if (start_go) begin
                words_loaded <= 6'd0;
                err          <= 1'b0;
                cpu_hold     <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                csum         <= 8'd0;
`endif
            end
            if (accept && (state == S_COUNT)) begin
                if (count_bad) err <= 1'b1;
                else           target <= (in_data == 8'd0) ? 6'(DEPTH) : in_data[5:0];
            end
            if (word_done) begin
                mem_addr     <= word_addr(words_loaded[WORD_IDX_W-1:0]);
                words_loaded <= words_loaded + 6'd1;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            if (accept && ((state == S_COUNT) || (state == S_DATA))) begin
                csum <= csum ^ in_data;
            end
            if (accept && (state == S_CHECK) && !csum_ok) begin
                err <= 1'b1;
            end
`endif
            if (next_state == S_DONE) begin
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (DEPTH=32, HOLD_AT_RESET=1).
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [5:0]  words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] csum_model = 8'd0;
`endif

    always #5 clk = ~clk;

    inst_loader #(.DEPTH(32), .HOLD_AT_RESET(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_model = 8'd0;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_model = csum_model ^ b;
`endif
    endtask

    // Called in the cycle carrying the final write; returns in the done cycle.
    task automatic to_done();
`ifdef INST_LOADER_CHECKSUM_EN
        tick();
        send_byte(csum_model);
`else
        tick();
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_we},   32'd0);
        chk({tag, "_addr"},  mem_addr,          32'd0);
        chk({tag, "_wdata"}, mem_wdata,         32'd0);
        chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_done"},  {31'd0, done},     32'd0);
        chk({tag, "_err"},   {31'd0, err},      32'd0);
        chk({tag, "_wl"},    {26'd0, words_loaded}, 32'd0);
    endtask

    logic [7:0] t1 [9] = '{8'h02, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        idle(2);
        check_reset_vals("rst");
        rst = 1'b0;
        tick();

        // Two-word load.
        wa.delete(); wd.delete();
        pulse_start();
        chk("t1_ready_after_start", {31'd0, in_ready}, 32'd1);
        chk("t1_hold_after_start", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            send_byte(t1[i]);
            if (i == 4) begin
                chk("t1_w0_we",   {31'd0, mem_we}, 32'd1);
                chk("t1_w0_addr", mem_addr, 32'h0000_0000);
                chk("t1_w0_data", mem_wdata, 32'h3C01_1234);
            end
        end
        chk("t1_w1_we",   {31'd0, mem_we}, 32'd1);
        chk("t1_w1_addr", mem_addr, 32'h0000_0004);
        chk("t1_w1_data", mem_wdata, 32'h3421_5678);
        chk("t1_wl",      {26'd0, words_loaded}, 32'd2);
        chk("t1_ready_closed", {31'd0, in_ready}, 32'd0);
        chk("t1_done_early", {31'd0, done}, 32'd0);
        chk("t1_hold_during", {31'd0, cpu_hold}, 32'd1);
        to_done();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_hold_released", {31'd0, cpu_hold}, 32'd0);
        tick();
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
        chk("t1_hold_stays_low", {31'd0, cpu_hold}, 32'd0);
        chk("t1_nwrites", wa.size(), 32'd2);
        chk("t1_log0_addr", wa[0], 32'h0000_0000);
        chk("t1_log0_data", wd[0], 32'h3C01_1234);
        chk("t1_log1_addr", wa[1], 32'h0000_0004);
        chk("t1_log1_data", wd[1], 32'h3421_5678);

        // Full-depth load via count byte 0.
        wa.delete(); wd.delete();
        pulse_start();
        chk("t2_hold_reasserted", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h00);
        for (int j = 0; j < 128; j++) send_byte(8'(j));
        chk("t2_last_we",   {31'd0, mem_we}, 32'd1);
        chk("t2_last_addr", mem_addr, 32'h0000_007C);
        chk("t2_wl",        {26'd0, words_loaded}, 32'd32);
        to_done();
        chk("t2_done", {31'd0, done}, 32'd1);
        tick();
        chk("t2_ready_after", {31'd0, in_ready}, 32'd0);
        chk("t2_nwrites", wa.size(), 32'd32);
        chk("t2_first_data", wd[0], 32'h0001_0203);
        chk("t2_last_log_addr", wa[31], 32'h0000_007C);
        chk("t2_last_log_data", wd[31], 32'h7C7D_7E7F);

        // Illegal count.
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h21);
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_ready_idle", {31'd0, in_ready}, 32'd0);
        chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
        idle(3);
        chk("t3_err_sticky", {31'd0, err}, 32'd1);
        chk("t3_nwrites", wa.size(), 32'd0);
        pulse_start();
        chk("t3_err_cleared", {31'd0, err}, 32'd0);
        chk("t3_ready_count", {31'd0, in_ready}, 32'd1);

        // One-word load with valid gaps and an ignored mid-load start.
        send_byte(8'h01);
        send_byte(8'hAC);
        idle(2);
        send_byte(8'h61);
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(1);
        send_byte(8'h00);
        idle(3);
        chk("t4_no_early_write", wa.size(), 32'd0);
        send_byte(8'h01);
        chk("t4_we",   {31'd0, mem_we}, 32'd1);
        chk("t4_addr", mem_addr, 32'h0000_0000);
        chk("t4_data", mem_wdata, 32'hAC61_0001);
        to_done();
        chk("t4_done", {31'd0, done}, 32'd1);
        tick();
        chk("t4_nwrites", wa.size(), 32'd1);
        in_data = 8'h99; in_valid = 1'b1;
        idle(3);
        in_valid = 1'b0;
        chk("t4_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_idle_wl", {26'd0, words_loaded}, 32'd1);
        chk("t4_idle_nwrites", wa.size(), 32'd1);

        // Reset in the middle of the second word.
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("t5");
        idle(3);
        chk("t5_nwrites", wa.size(), 32'd1);
        chk("t5_log_data", wd[0], 32'h1122_3344);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("t5_reload_data", mem_wdata, 32'hDEAD_BEEF);
        chk("t5_reload_addr", mem_addr, 32'h0000_0000);
        to_done();
        chk("t5_reload_done", {31'd0, done}, 32'd1);
        chk("t5_reload_hold", {31'd0, cpu_hold}, 32'd0);
        tick();

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h22); send_byte(8'h18); send_byte(8'h20);
        tick();
        send_byte(8'h1B);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
        tick();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h22); send_byte(8'h18); send_byte(8'h20);
        tick();
        send_byte(8'h1C);
        chk("t6_bad_err", {31'd0, err}, 32'd1);
        chk("t6_bad_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t6_bad_done", {31'd0, done}, 32'd0);
        tick();
        chk("t6_bad_no_done", {31'd0, done}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
